// File: rtl/my_pipelined_adder.sv
// my_pipelined_adder
//   Pipelined adder/subtractor. A WIDTH-bit operation is split into STAGES
//   chunks of CHUNK = WIDTH/STAGES bits. Rank k adds chunk k and registers
//   the carry for rank k+1, so the longest combinational path is one
//   CHUNK-bit ripple. One operation per cycle, results in order.
//
//   Optional feature: define MY_PIPELINED_ADDER_SAT_EN to saturate sum on
//   signed overflow (0x7F..F for positive overflow, 0x80..0 for negative).
//   Without it, sum wraps modulo 2^WIDTH.
//
// Parameters
//   WIDTH     operand/result width, must be a multiple of STAGES
//   STAGES    pipeline ranks, 1..WIDTH
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/sub valid
//   in_ready   block accepts this cycle
//   a, b       operands (unsigned or two's complement)
//   sub        0: a+b, 1: a-b (a + ~b + 1)
//   out_valid  sum/carry/overflow hold a result
//   out_ready  downstream accepts the result
//   sum        result
//   carry      raw carry out of the MSB (subtract: 1 = no borrow)
//   overflow   signed overflow
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. The whole pipeline advances together (adv = !out_valid ||
// out_ready); in_ready equals adv, so it falls combinationally in the cycle
// the output is stalled. valid never depends on ready; outputs hold stable
// while out_valid && !out_ready. Bubbles are carried, not collapsed.

module my_pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int CHUNK = WIDTH / STAGES;

   logic             adv;
   logic [WIDTH-1:0] b_eff;

   // Per-rank state. Operands travel full width so the final rank still has
   // the operand MSBs needed for the overflow term.
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] cry_q;
   logic [WIDTH-1:0]  opa_q [STAGES];
   logic [WIDTH-1:0]  opb_q [STAGES];
   logic [WIDTH-1:0]  res_q [STAGES];

   // Per-rank inputs (from the block inputs for rank 0, else from rank k-1)
   // and next-state values.
   logic [STAGES-1:0] v_src;
   logic [STAGES-1:0] cin_src;
   logic [STAGES-1:0] cry_d;
   logic [WIDTH-1:0]  a_src   [STAGES];
   logic [WIDTH-1:0]  b_src   [STAGES];
   logic [WIDTH-1:0]  res_src [STAGES];
   logic [WIDTH-1:0]  res_d   [STAGES];
   logic [CHUNK:0]    part    [STAGES];

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Subtraction is a + ~b + 1: invert b here, inject the +1 as rank 0 carry-in.
   assign b_eff = sub ? ~b : b;

   always_comb begin
      v_src[0]   = in_valid;
      cin_src[0] = sub;
      a_src[0]   = a;
      b_src[0]   = b_eff;
      res_src[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         v_src[k]   = vld_q[k-1];
         cin_src[k] = cry_q[k-1];
         a_src[k]   = opa_q[k-1];
         b_src[k]   = opb_q[k-1];
         res_src[k] = res_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, cin_src[k]};
         res_d[k] = res_src[k];
         res_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
         cry_d[k] = part[k][CHUNK];
      end
   end

   // Valid bits move on every advance; data registers load only when the
   // incoming slot is valid, so bubbles leave stale data behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         cry_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            opa_q[k] <= '0;
            opb_q[k] <= '0;
            res_q[k] <= '0;
         end
      end else if (adv) begin
         vld_q <= v_src;
         for (int k = 0; k < STAGES; k++) begin
            if (v_src[k]) begin
               opa_q[k] <= a_src[k];
               opb_q[k] <= b_src[k];
               res_q[k] <= res_d[k];
               cry_q[k] <= cry_d[k];
            end
         end
      end
   end

   logic             a_msb;
   logic             b_msb;
   logic [WIDTH-1:0] raw_sum;

   assign a_msb   = opa_q[STAGES-1][WIDTH-1];
   assign b_msb   = opb_q[STAGES-1][WIDTH-1];
   assign raw_sum = res_q[STAGES-1];

   assign out_valid = vld_q[STAGES-1];
   assign carry     = cry_q[STAGES-1];
   // Same-sign operands producing a result of the other sign.
   assign overflow  = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);

`ifdef MY_PIPELINED_ADDER_SAT_EN
   // On overflow the operands share a's sign, so a's MSB picks the rail.
   assign sum = !overflow ? raw_sum :
                a_msb     ? {1'b1, {(WIDTH-1){1'b0}}} :
                            {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign sum = raw_sum;
`endif

endmodule

// File: tb/tb_my_pipelined_adder.sv
// Bench for my_pipelined_adder (WIDTH=16, STAGES=4). Expected results come
// from signed/unsigned integer arithmetic on the operands, queued at accept
// time and compared in order whenever a result transfers.

module tb_my_pipelined_adder;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;

   int checks = 0;
   int errors = 0;

   // {carry, overflow, sum}
   logic [WIDTH+1:0] exp_q[$];

   logic             stall_prev = 1'b0;
   logic [WIDTH+1:0] stall_val  = '0;
   logic             stream_on  = 1'b0;

   my_pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .overflow  (overflow)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, independent of chunking.
   function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic msub);
      longint ua, ub, sa, sb, ur, sr, smax, smin;
      logic c, o;
      logic [WIDTH-1:0] s;
      ua   = longint'(ma);
      ub   = longint'(mb);
      sa   = longint'($signed(ma));
      sb   = longint'($signed(mb));
      smax = (longint'(1) << (WIDTH-1)) - 1;
      smin = -(longint'(1) << (WIDTH-1));
      if (msub) begin
         ur = ua - ub;
         sr = sa - sb;
         c  = (ua >= ub);
      end else begin
         ur = ua + ub;
         sr = sa + sb;
         c  = (ur >= (longint'(1) << WIDTH));
      end
      o = (sr > smax) || (sr < smin);
      s = ur[WIDTH-1:0];
`ifdef MY_PIPELINED_ADDER_SAT_EN
      if (o) s = (sr > 0) ? smax[WIDTH-1:0] : smin[WIDTH-1:0];
`endif
      return {c, o, s};
   endfunction

   // ---------------- scoreboard / compare process ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
         if (stall_prev) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_hold", {14'd0, carry, overflow, sum}, {14'd0, stall_val});
         end
         stall_prev = out_valid && !out_ready;
         stall_val  = {carry, overflow, sum};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got 0x%0h expected no result at %0t", sum, $time);
            end else begin
               logic [WIDTH+1:0] e;
               e = exp_q.pop_front();
               chk("model_result", {14'd0, carry, overflow, sum}, {14'd0, e});
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
      end
   end

   // ---------------- driver tasks ----------------
   // One isolated operation with literal expectations and a latency check:
   // accepted at edge N, out_valid must stay low through N+STAGES-2 and be
   // high right after N+STAGES-1.
   task automatic run_directed(input string name,
                               input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                               input logic dsub, input logic [WIDTH-1:0] esum,
                               input logic ecarry, input logic eovf);
      @(posedge clk);
      #1;
      a = da; b = db; sub = dsub; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < STAGES-1; i++) begin
         chk({name, "_early"}, {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_sum"}, {16'd0, sum}, {16'd0, esum});
      chk({name, "_carry"}, {31'd0, carry}, {31'd0, ecarry});
      chk({name, "_ovf"}, {31'd0, overflow}, {31'd0, eovf});
   endtask

   // Present one operation and hold it until accepted (bounded).
   task automatic send_wait(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                            input logic dsub);
      logic acc;
      a = da; b = db; sub = dsub; in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      chk("accept_timeout", {31'd0, acc}, 32'd1);
   endtask

   // ---------------- out_ready toggler ----------------
   initial begin
      wait (stream_on);
      while (stream_on) begin
         @(posedge clk);
         #1;
         if (stream_on) out_ready = 1'(($urandom_range(0, 1)));
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_carry", {31'd0, carry}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      run_directed("add_basic", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_directed("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_directed("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
`ifdef MY_PIPELINED_ADDER_SAT_EN
      run_directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      run_directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
      run_directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

      // Back-to-back stream with random backpressure.
      @(posedge clk);
      #1;
      stream_on = 1'b1;
      for (int i = 0; i < 16; i++)
         send_wait(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                   1'($urandom_range(0, 1)));
      in_valid  = 1'b0;
      stream_on = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
      chk("drain_empty", exp_q.size(), 32'd0);

      // Reset with operations in flight, one of them already at the output.
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         a = 16'h1111 * 16'(i + 1); b = 16'h0101; sub = 1'b0; in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_sum", {16'd0, sum}, 32'd0);
      chk("midrst_carry", {31'd0, carry}, 32'd0);
      chk("midrst_ovf", {31'd0, overflow}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("no_stale", {31'd0, out_valid}, 32'd0);
      end
      run_directed("post_reset", 16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      chk("final_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
